// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: hc/vc counters gated by pix_ce, with sync/blank realigned
// to a renderer that returns colour PIPE pixel ticks after the request.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CW       = 10,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2,
  parameter int unsigned FC_W     = 8
) (
  input  logic            dclk,
  input  logic            clr_n,
  input  logic            pix_ce,
  output logic [CW-1:0]   px_x,
  output logic [CW-1:0]   px_y,
  output logic            px_valid,
  input  logic [R_W-1:0]  r_in,
  input  logic [G_W-1:0]  g_in,
  input  logic [B_W-1:0]  b_in,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output logic [R_W-1:0]  red,
  output logic [G_W-1:0]  green,
  output logic [B_W-1:0]  blue,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned DEPTH   = (PIPE == 0) ? 1 : PIPE;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYN  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYN  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_BEG  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_BEG  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_END  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_END  = CW'(V_SYNC + V_BP + V_ACTIVE);

  // Tap layout: {hsync, vsync, valid}; reset value is sync deasserted, not valid.
  localparam logic [2:0] TAP_RST = {~HS_POL, ~VS_POL, 1'b0};

  initial begin
    if (PIPE > 7) $error("vga_timing_gen: PIPE=%0d out of range 0..7", PIPE);
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0)
      $error("vga_timing_gen: CW=%0d too narrow for %0dx%0d totals", CW, H_TOTAL, V_TOTAL);
  end

  logic [CW-1:0] hc_q, vc_q;
  logic          h_wrap, v_wrap, h_act, v_act;
  logic [2:0]    raw, tap;
  logic [2:0]    dly_q [DEPTH];

  assign h_wrap   = (hc_q == H_LAST);
  assign v_wrap   = (vc_q == V_LAST);
  assign h_act    = (hc_q >= H_BEG) && (hc_q < H_END);
  assign v_act    = (vc_q >= V_BEG) && (vc_q < V_END);
  assign px_valid = h_act & v_act;
  assign px_x     = px_valid ? (hc_q - H_BEG) : '0;
  assign px_y     = px_valid ? (vc_q - V_BEG) : '0;

  assign raw = {(hc_q < H_SYN) ? HS_POL : ~HS_POL,
                (vc_q < V_SYN) ? VS_POL : ~VS_POL,
                px_valid};

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        hc_q <= '0;
        vc_q <= v_wrap ? '0 : vc_q + CW'(1);
      end else begin
        hc_q <= hc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < int'(DEPTH); i++) dly_q[i] <= TAP_RST;
    end else if (pix_ce) begin
      dly_q[0] <= raw;
      for (int i = 1; i < int'(DEPTH); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // With PIPE=0 the output registers sample the live decode directly.
  assign tap = (PIPE == 0) ? raw : dly_q[DEPTH-1];

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      blank <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_ce) begin
      hsync <= tap[2];
      vsync <= tap[1];
      blank <= ~tap[0];
      red   <= tap[0] ? r_in : '0;
      green <= tap[0] ? g_in : '0;
      blue  <= tap[0] ? b_in : '0;
    end
  end

  // Strobes update every dclk so they last exactly one cycle even when pix_ce is sparse.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= pix_ce & h_wrap;
      frame_start <= pix_ce & h_wrap & v_wrap;
      if (pix_ce && h_wrap && v_wrap) frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small mode: PIPE=2 active-low instance plus a PIPE=0
// active-high instance, checked cycle by cycle against a queued reference model.
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HS + HBP + HA + HFP;  // 17
  localparam int VT = VS + VBP + VA + VFP;  // 9
  localparam int HB = HS + HBP;
  localparam int VB = VS + VBP;
  localparam int PIPE = 2;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] rgb;
  } exp_t;

  logic       dclk = 1'b0;
  logic       clr_n, pix_ce;
  logic [2:0] r_in, g_in;
  logic [1:0] b_in;
  logic [4:0] px_x, px_y;
  logic       px_valid, hsync, vsync, blank, line_start, frame_start;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [7:0] frame_cnt;

  logic [4:0] px_x2, px_y2;
  logic       px_valid2, hsync2, vsync2, blank2, line_start2, frame_start2;
  logic [2:0] red2, green2, r2_in;
  logic [2:0] g2_in = 3'd0;
  logic [1:0] b2_in = 2'd0;
  logic [1:0] blue2;
  logic [7:0] frame_cnt2;

  assign r2_in = px_x2[2:0];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(PIPE), .CW(5), .FC_W(8)
  ) dut (
    .dclk(dclk), .clr_n(clr_n), .pix_ce(pix_ce),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .red(red), .green(green), .blue(blue),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(0), .CW(5), .FC_W(8)
  ) dut_pol (
    .dclk(dclk), .clr_n(clr_n), .pix_ce(pix_ce),
    .px_x(px_x2), .px_y(px_y2), .px_valid(px_valid2),
    .r_in(r2_in), .g_in(g2_in), .b_in(b2_in),
    .hsync(hsync2), .vsync(vsync2), .blank(blank2),
    .red(red2), .green(green2), .blue(blue2),
    .line_start(line_start2), .frame_start(frame_start2), .frame_cnt(frame_cnt2)
  );

  always #5 dclk = ~dclk;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  exp_t e1;
  logic e2_hs, e2_vs, e2_bl;
  logic [2:0] e2_r;
  int   hc_m, vc_m;
  logic [7:0] fc_m;
  logic e_ls, e_fs;
  logic [7:0] rend0, rend1;
  int   hs_low, vs_low, bl_low, ls_cnt, fs_cnt, hs2_hi, last_hs_fall;
  logic prev_hs;

  function automatic exp_t exp_of(input int h, input int v);
    exp_t e;
    logic ok;
    logic [4:0] x, y;
    ok    = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
    x     = ok ? 5'(h - HB) : 5'd0;
    y     = ok ? 5'(v - VB) : 5'd0;
    e.hs  = !(h < HS);
    e.vs  = !(v < VS);
    e.bl  = !ok;
    e.rgb = ok ? {x[2:0], y[2:0], x[1:0]} : 8'd0;
    return e;
  endfunction

  task automatic model_reset();
    hc_m = 0; vc_m = 0; fc_m = 8'd0;
    q.delete();
    for (int i = 0; i < PIPE; i++) q.push_back(exp_t'({1'b1, 1'b1, 1'b1, 8'd0}));
    e1 = exp_t'({1'b1, 1'b1, 1'b1, 8'd0});
    e2_hs = 1'b0; e2_vs = 1'b0; e2_bl = 1'b1; e2_r = 3'd0;
    e_ls = 1'b0; e_fs = 1'b0;
    rend0 = 8'hFF; rend1 = 8'hFF;
  endtask

  // One dclk: drive at negedge, push/pop the scoreboard, compare at the next negedge.
  task automatic step(input bit ce);
    exp_t nx, cur;
    logic [31:0] obs1, exp1;
    logic [5:0]  obs2, exp2;
    pix_ce = ce;
    if (ce) begin
      {r_in, g_in, b_in} = rend1;
      rend1 = rend0;
      rend0 = px_valid ? {px_x[2:0], px_y[2:0], px_x[1:0]} : 8'hFF;
      nx = exp_of(hc_m, vc_m);
      q.push_back(nx);
      e1 = q.pop_front();
      e2_hs = ~nx.hs; e2_vs = ~nx.vs; e2_bl = nx.bl;
      e2_r  = nx.bl ? 3'd0 : 3'(hc_m - HB);
      e_ls  = (hc_m == HT - 1);
      e_fs  = e_ls && (vc_m == VT - 1);
      if (e_fs) fc_m = fc_m + 8'd1;
      if (hc_m == HT - 1) begin
        hc_m = 0;
        vc_m = (vc_m == VT - 1) ? 0 : vc_m + 1;
      end else begin
        hc_m = hc_m + 1;
      end
    end else begin
      {r_in, g_in, b_in} = 8'($urandom);
      e_ls = 1'b0; e_fs = 1'b0;
    end
    @(posedge dclk);
    @(negedge dclk);
    cyc++;
    cur  = exp_of(hc_m, vc_m);
    obs1 = {px_valid, px_x, px_y, hsync, vsync, blank, red, green, blue,
            line_start, frame_start, frame_cnt};
    exp1 = {~cur.bl, cur.bl ? 5'd0 : 5'(hc_m - HB), cur.bl ? 5'd0 : 5'(vc_m - VB),
            e1.hs, e1.vs, e1.bl, e1.rgb, e_ls, e_fs, fc_m};
    checks++;
    if (obs1 !== exp1) begin
      errors++;
      $display("FAIL sb_main cyc=%0d hc=%0d vc=%0d got %h want %h", cyc, hc_m, vc_m, obs1, exp1);
    end
    obs2 = {hsync2, vsync2, blank2, red2};
    exp2 = {e2_hs, e2_vs, e2_bl, e2_r};
    checks++;
    if (obs2 !== exp2) begin
      errors++;
      $display("FAIL sb_pol cyc=%0d got %b want %b", cyc, obs2, exp2);
    end
    hs_low += (hsync == 1'b0) ? 1 : 0;
    vs_low += (vsync == 1'b0) ? 1 : 0;
    bl_low += (blank == 1'b0) ? 1 : 0;
    hs2_hi += (hsync2 == 1'b1) ? 1 : 0;
    ls_cnt += (line_start == 1'b1) ? 1 : 0;
    fs_cnt += (frame_start == 1'b1) ? 1 : 0;
    if (prev_hs && !hsync) last_hs_fall = cyc;
    prev_hs = hsync;
  endtask

  task automatic clear_counts();
    hs_low = 0; vs_low = 0; bl_low = 0; ls_cnt = 0; fs_cnt = 0; hs2_hi = 0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; pix_ce = 1'b1; r_in = 3'd7; g_in = 3'd7; b_in = 2'd3;
    repeat (3) @(negedge dclk);
    checks++;
    if ({hsync, vsync, blank, red, green, blue, line_start, frame_start, frame_cnt, px_valid}
        !== {1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_main got hs=%b vs=%b bl=%b rgb=%h fc=%0d", hsync, vsync, blank,
               {red, green, blue}, frame_cnt);
    end
    checks++;
    if ({hsync2, vsync2, blank2, red2} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_pol got %b want 001000", {hsync2, vsync2, blank2, red2});
    end
    model_reset();
    prev_hs = 1'b1;
    clr_n = 1'b1;
  endtask

  task automatic test_blank_align();
    int n, first_hs, t_valid, lat, width, fall_gap;
    logic [7:0] first_rgb, last_rgb;
    first_hs = -1; t_valid = -1;
    for (n = 1; n <= 200; n++) begin
      step(1'b1);
      if (first_hs < 0 && hsync == 1'b0) first_hs = n;
      if (px_valid) begin
        t_valid = n;
        break;
      end
    end
    checks++;
    if (first_hs !== PIPE + 1) begin
      errors++;
      $display("FAIL first_sync got %0d want %0d", first_hs, PIPE + 1);
    end
    checks++;
    if (t_valid !== VB * HT + HB) begin
      errors++;
      $display("FAIL first_valid got %0d want %0d", t_valid, VB * HT + HB);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (!blank) begin
        lat = i;
        break;
      end
    end
    fall_gap  = cyc - last_hs_fall;
    first_rgb = {red, green, blue};
    checks++;
    if (lat !== PIPE + 1) begin
      errors++;
      $display("FAIL valid_to_blank got %0d want %0d", lat, PIPE + 1);
    end
    checks++;
    if (fall_gap !== HB) begin
      errors++;
      $display("FAIL hsync_to_blank got %0d want %0d", fall_gap, HB);
    end
    checks++;
    if (first_rgb !== 8'h00) begin
      errors++;
      $display("FAIL first_pixel got %h want 00", first_rgb);
    end
    width = -1; last_rgb = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (!blank) last_rgb = {red, green, blue};
      step(1'b1);
      if (blank) begin
        width = i;
        break;
      end
    end
    checks++;
    if (width !== HA) begin
      errors++;
      $display("FAIL blank_low_width got %0d want %0d", width, HA);
    end
    checks++;
    if (last_rgb !== 8'hE3) begin
      errors++;
      $display("FAIL last_pixel got %h want e3", last_rgb);
    end
  endtask

  task automatic test_timing();
    clear_counts();
    repeat (2 * FT) step(1'b1);
    checks++;
    if (hs_low !== 2 * HS * VT) begin
      errors++;
      $display("FAIL hsync_low got %0d want %0d", hs_low, 2 * HS * VT);
    end
    checks++;
    if (vs_low !== 2 * VS * HT) begin
      errors++;
      $display("FAIL vsync_low got %0d want %0d", vs_low, 2 * VS * HT);
    end
    checks++;
    if (bl_low !== 2 * HA * VA) begin
      errors++;
      $display("FAIL active_count got %0d want %0d", bl_low, 2 * HA * VA);
    end
    checks++;
    if (hs2_hi !== 2 * HS * VT) begin
      errors++;
      $display("FAIL pol_hsync_high got %0d want %0d", hs2_hi, 2 * HS * VT);
    end
    checks++;
    if (ls_cnt !== 2 * VT || fs_cnt !== 2) begin
      errors++;
      $display("FAIL strobe_count got ls=%0d fs=%0d want ls=%0d fs=2", ls_cnt, fs_cnt, 2 * VT);
    end
  endtask

  task automatic test_ce_quarter();
    int last_ls, period;
    logic [10:0] snap;
    last_ls = -1; period = -1;
    clear_counts();
    for (int i = 0; i < 4 * HT * 3; i++) begin
      snap = {hsync, vsync, blank, red, green, blue};
      step(i % 4 == 0);
      if (i % 4 != 0) begin
        checks++;
        if ({hsync, vsync, blank, red, green, blue} !== snap) begin
          errors++;
          $display("FAIL hold_between_ticks cyc=%0d got %h want %h", cyc,
                   {hsync, vsync, blank, red, green, blue}, snap);
        end
      end
      if (line_start) begin
        if (last_ls >= 0 && period < 0) period = cyc - last_ls;
        last_ls = cyc;
      end
    end
    checks++;
    if (period !== 4 * HT) begin
      errors++;
      $display("FAIL line_period_x4 got %0d want %0d", period, 4 * HT);
    end
    checks++;
    if (ls_cnt !== 3) begin
      errors++;
      $display("FAIL line_start_x4 got %0d want 3", ls_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] prev_fc;
    bit wrapped;
    wrapped = 1'b0;
    for (int n = 0; n < 257 * FT; n++) begin
      prev_fc = frame_cnt;
      step(1'b1);
      if (frame_start && prev_fc == 8'd255) begin
        wrapped = 1'b1;
        checks++;
        if (frame_cnt !== 8'd0) begin
          errors++;
          $display("FAIL frame_cnt_wrap got %0d want 0", frame_cnt);
        end
        break;
      end
    end
    if (!wrapped) begin
      checks++;
      errors++;
      $display("FAIL frame_cnt_wrap got no wrap want 255->0");
    end
    clear_counts();
    repeat (FT) step(1'b1);
    checks++;
    if (fs_cnt !== 1) begin
      errors++;
      $display("FAIL frame_start_per_frame got %0d want 1", fs_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int t_valid;
    for (int n = 0; n < 2 * FT && !(hc_m == 10 && vc_m == 5); n++) step(1'b1);
    clr_n = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, blank, red, green, blue, line_start, frame_start, frame_cnt, px_valid,
         hsync2, vsync2, blank2}
        !== {1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got hs=%b vs=%b bl=%b fc=%0d valid=%b hs2=%b", hsync, vsync,
               blank, frame_cnt, px_valid, hsync2);
    end
    repeat (2) @(negedge dclk);
    model_reset();
    prev_hs = 1'b1;
    clr_n = 1'b1;
    clear_counts();
    t_valid = -1;
    for (int n = 1; n <= 200; n++) begin
      step(1'b1);
      if (px_valid) begin
        t_valid = n;
        break;
      end
    end
    checks++;
    if (t_valid !== VB * HT + HB) begin
      errors++;
      $display("FAIL restart_valid got %0d want %0d", t_valid, VB * HT + HB);
    end
    checks++;
    if (fs_cnt !== 0) begin
      errors++;
      $display("FAIL partial_frame_start got %0d want 0", fs_cnt);
    end
  endtask

  initial begin
    clear_counts();
    last_hs_fall = 0;
    prev_hs = 1'b1;
    test_reset();
    test_blank_align();
    test_timing();
    test_ce_quarter();
    test_frame_wrap();
    test_mid_reset();
    repeat (FT) step(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
